// File: rtl/logic_op_stage_if.sv
// Handshake bundle between decode, the logic execute stage and writeback.
// The master modport belongs to the side that drives operations and consumes results.
interface logic_op_stage_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_sel;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [1:0]       out_op;
    logic [1:0]       count;

    modport master (
        output in_valid, in_op, in_sel, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y, out_op, count
    );

    modport slave (
        input  in_valid, in_op, in_sel, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y, out_op, count
    );
endinterface

// File: rtl/logic_op_stage.sv
// Registered AND/OR/XOR/MUX execute stage with a two-entry result buffer (head + skid).
// state | meaning
// EMPTY | no result buffered, out_valid low, head cleared to zero
// ONE   | head holds the only result
// FULL  | head holds the oldest result, skid the newer one; input stalled
module logic_op_stage #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    logic_op_stage_if.slave     bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] head_y;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] skid_y;
    logic [1:0]       skid_op;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;
    logic             ready;

    always_comb begin
        result = '0;
        case (bus.in_op)
            2'b00:   result = bus.in_a & bus.in_b;
            2'b01:   result = bus.in_a | bus.in_b;
            2'b10:   result = bus.in_a ^ bus.in_b;
            default: result = bus.in_sel ? bus.in_b : bus.in_a;
        endcase
    end

    // Ready is gated by rst so a push presented during reset is never handshaken.
    assign ready = (state != FULL) && !rst;
    assign push  = bus.in_valid && ready;
    assign pop   = (state != EMPTY) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            head_y  <= '0;
            head_op <= '0;
            skid_y  <= '0;
            skid_op <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_y  <= result;
                        head_op <= bus.in_op;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_y  <= result;
                        head_op <= bus.in_op;
                    end else if (push) begin
                        skid_y  <= result;
                        skid_op <= bus.in_op;
                        state   <= FULL;
                    end else if (pop) begin
                        head_y  <= '0;
                        head_op <= '0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_y  <= skid_y;
                        head_op <= skid_op;
                        skid_y  <= '0;
                        skid_op <= '0;
                        state   <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    head_y  <= '0;
                    head_op <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state != EMPTY);
    assign bus.out_y     = head_y;
    assign bus.out_op    = head_op;
    assign bus.count     = state;
endmodule
